ibex_fetch_req_ctrl: RTL

- Memory-side initiator that feeds the instruction fetch FIFO.
- Generates word-aligned instruction requests on a req/gnt/rvalid bus and tracks outstanding transactions.
- Buffers in-order responses and pushes them, with their addresses, into the FIFO input port (addr/rdata/valid/ready).
- On a branch it redirects fetch, clears the FIFO and discards stale in-flight responses.

---
 rtl/ibex_fetch_req_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ibex_fetch_req_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ibex_fetch_req_ctrl                                             |
// | Purpose  : Instruction-fetch request initiator feeding the fetch FIFO;     |
// |            optional response error path under macro FETCH_REQ_ERR_EN.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ibex_fetch_req_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
`ifdef FETCH_REQ_ERR_EN
  input  logic        instr_err_i,
  output logic        fifo_err_o,
`endif
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  output logic        fifo_valid_o,
  input  logic        fifo_ready_i,
  output logic        fifo_clear_o,
  output logic        busy_o
);

  localparam int unsigned     PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [2:0]      MAX_CNT  = 3'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE           = 2'd0,
    ST_WAIT_GNT       = 2'd1,
    ST_WAIT_GNT_STALE = 2'd2
  } state_e;

  state_e             r_state, w_state_next;
  logic [29:0]        r_fetch_word;
  logic [29:0]        r_req_word;
  logic [29:0]        r_resp_word;
  logic [31:0]        r_target;
  logic               r_first;
  logic               r_err_lock;
  logic [1:0]         r_outstanding;
  logic [1:0]         r_discard;
  logic [1:0]         r_count;
  logic [PTR_W-1:0]   r_rd_ptr, r_wr_ptr;
  logic [31:0]        r_buf_addr [MAX_OUTSTANDING];
  logic [31:0]        r_buf_data [MAX_OUTSTANDING];
`ifdef FETCH_REQ_ERR_EN
  logic               r_buf_err  [MAX_OUTSTANDING];
`endif

  logic        w_credit, w_issue, w_gnt, w_stale_gnt, w_push, w_pop, w_rsp_err;
  logic [1:0]  w_out_next;
  logic [31:0] w_push_addr;
  logic        w_unused_addr_b0;

  assign w_unused_addr_b0 = branch_addr_i[0];

`ifdef FETCH_REQ_ERR_EN
  assign w_rsp_err  = instr_err_i;
  assign fifo_err_o = r_buf_err[r_rd_ptr];
`else
  assign w_rsp_err  = 1'b0;
`endif

  // Credit covers both in-flight requests and responses parked in the buffer.
  assign w_credit = ({1'b0, r_outstanding} + {1'b0, r_count}) < MAX_CNT;
  assign w_issue  = fetch_en_i & w_credit & ~r_err_lock;

  always_comb begin
    w_state_next = r_state;
    instr_req_o  = 1'b0;
    instr_addr_o = {r_req_word, 2'b00};
    case (r_state)
      ST_IDLE: begin
        instr_addr_o = {r_fetch_word, 2'b00};
        if (w_issue) begin
          instr_req_o = 1'b1;
          if (!instr_gnt_i) begin
            w_state_next = branch_i ? ST_WAIT_GNT_STALE : ST_WAIT_GNT;
          end
        end
      end
      ST_WAIT_GNT: begin
        instr_req_o = 1'b1;
        if (instr_gnt_i) begin
          w_state_next = ST_IDLE;
        end else if (branch_i) begin
          w_state_next = ST_WAIT_GNT_STALE;
        end
      end
      ST_WAIT_GNT_STALE: begin
        instr_req_o = 1'b1;
        if (instr_gnt_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_gnt       = instr_req_o & instr_gnt_i;
  assign w_stale_gnt = w_gnt & (r_state == ST_WAIT_GNT_STALE);
  assign w_push      = instr_rvalid_i & ~branch_i & (r_discard == 2'd0);
  assign w_pop       = fifo_valid_o & fifo_ready_i & ~branch_i;
  assign w_out_next  = r_outstanding + 2'(w_gnt) - 2'(instr_rvalid_i);
  assign w_push_addr = r_first ? r_target : {r_resp_word, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_fetch_word  <= BOOT_ADDR[31:2];
      r_req_word    <= BOOT_ADDR[31:2];
      r_resp_word   <= BOOT_ADDR[31:2];
      r_target      <= {BOOT_ADDR[31:2], 2'b00};
      r_first       <= 1'b0;
      r_err_lock    <= 1'b0;
      r_outstanding <= 2'd0;
      r_discard     <= 2'd0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_out_next;
      // Held requests replay the address captured while still in IDLE.
      if (r_state == ST_IDLE) begin
        r_req_word <= r_fetch_word;
      end
      if (branch_i) begin
        r_fetch_word <= branch_addr_i[31:2];
        r_resp_word  <= branch_addr_i[31:2];
        r_target     <= {branch_addr_i[31:1], 1'b0};
        r_first      <= 1'b1;
        r_err_lock   <= 1'b0;
        r_discard    <= w_out_next;
      end else begin
        if (w_gnt && !w_stale_gnt) begin
          r_fetch_word <= r_fetch_word + 30'd1;
        end
        if (w_push) begin
          r_first     <= 1'b0;
          r_resp_word <= r_resp_word + 30'd1;
          if (w_rsp_err) begin
            r_err_lock <= 1'b1;
          end
        end
        r_discard <= r_discard - 2'(instr_rvalid_i && (r_discard != 2'd0)) + 2'(w_stale_gnt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_buf_addr[i] <= '0;
        r_buf_data[i] <= '0;
`ifdef FETCH_REQ_ERR_EN
        r_buf_err[i]  <= 1'b0;
`endif
      end
    end else if (branch_i) begin
      r_count  <= 2'd0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_buf_addr[r_wr_ptr] <= w_push_addr;
        r_buf_data[r_wr_ptr] <= instr_rdata_i;
`ifdef FETCH_REQ_ERR_EN
        r_buf_err[r_wr_ptr]  <= w_rsp_err;
`endif
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  assign fifo_valid_o = (r_count != 2'd0);
  assign fifo_addr_o  = r_buf_addr[r_rd_ptr];
  assign fifo_rdata_o = r_buf_data[r_rd_ptr];
  assign fifo_clear_o = branch_i;
  assign busy_o       = (r_outstanding != 2'd0) || (r_count != 2'd0);

endmodule
`default_nettype wire
